// File: rtl/xctrl_mc_if.sv
// Bus bundle for xctrl_mc: program fetch handshake, data memory handshake and status.
// master = controller side, slave = memory/bus side.
interface xctrl_mc_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int PC_W    = 15,
  parameter int INSTR_W = 32
);
  logic               instr_req;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] instruction;
  logic               instr_ack;
  logic               data_mem_sel;
  logic               data_mem_we;
  logic [ADDR_W-1:0]  data_mem_addr;
  logic [DATA_W-1:0]  data_to_mem;
  logic [DATA_W-1:0]  data_from_mem;
  logic               data_mem_ack;
  logic [3:0]         flags;
  logic               instr_done;

  modport master (
    output instr_req, pc, data_mem_sel, data_mem_we, data_mem_addr, data_to_mem,
           flags, instr_done,
    input  instruction, instr_ack, data_from_mem, data_mem_ack
  );

  modport slave (
    input  instr_req, pc, data_mem_sel, data_mem_we, data_mem_addr, data_to_mem,
           flags, instr_done,
    output instruction, instr_ack, data_from_mem, data_mem_ack
  );
endinterface

// File: rtl/xctrl_mc.sv
// Multi-cycle accumulator controller with req/ack program and data memories.
//   state | meaning
//   FETCH | instr_req held with pc until instr_ack, instruction latched into IR
//   EXEC  | decode; register/immediate/branch ops retire here, external accesses go to MEM
//   MEM   | data_mem_sel/addr/we/data held until data_mem_ack, then retire
module xctrl_mc #(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 16,
  parameter int          PC_W    = 15,
  parameter int          INSTR_W = 32,
  parameter int          IMM_W   = 16,
  parameter int unsigned RB_ADDR = 32'h0000_FFFE,
  parameter int unsigned RC_ADDR = 32'h0000_FFFF
) (
  input logic          clk,
  input logic          rst,
  xctrl_mc_if.master   bus
);

  localparam int OPCODESZ = 5;
  localparam int SH_W     = $clog2(DATA_W) + 1;
  localparam logic [ADDR_W-1:0] RB_A = RB_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] RC_A = RC_ADDR[ADDR_W-1:0];

  localparam logic [OPCODESZ-1:0] OP_NOP   = 5'd0;
  localparam logic [OPCODESZ-1:0] OP_LDI   = 5'd1;
  localparam logic [OPCODESZ-1:0] OP_LDIH  = 5'd2;
  localparam logic [OPCODESZ-1:0] OP_ADDI  = 5'd3;
  localparam logic [OPCODESZ-1:0] OP_RDW   = 5'd4;
  localparam logic [OPCODESZ-1:0] OP_WRW   = 5'd5;
  localparam logic [OPCODESZ-1:0] OP_RDWB  = 5'd6;
  localparam logic [OPCODESZ-1:0] OP_WRWB  = 5'd7;
  localparam logic [OPCODESZ-1:0] OP_ADD   = 5'd8;
  localparam logic [OPCODESZ-1:0] OP_SUB   = 5'd9;
  localparam logic [OPCODESZ-1:0] OP_AND   = 5'd10;
  localparam logic [OPCODESZ-1:0] OP_XOR   = 5'd11;
  localparam logic [OPCODESZ-1:0] OP_SHFT  = 5'd12;
  localparam logic [OPCODESZ-1:0] OP_BEQI  = 5'd13;
  localparam logic [OPCODESZ-1:0] OP_BNEQI = 5'd14;
  localparam logic [OPCODESZ-1:0] OP_BEQ   = 5'd15;
  localparam logic [OPCODESZ-1:0] OP_BNEQ  = 5'd16;

  typedef enum logic [1:0] {FETCH, EXEC, MEM} state_t;

  state_t              state;
  logic [OPCODESZ-1:0] ir_op;
  logic [IMM_W-1:0]    ir_imm;
  logic [DATA_W-1:0]   reg_a, reg_b;
  logic [3:0]          reg_c;
  logic [PC_W-1:0]     pc_r;
  logic                instr_req_r, sel_r, we_r, done_r;
  logic [ADDR_W-1:0]   addr_r;

  logic [DATA_W-1:0]        imm_ext, opnd, b_x, alu_res;
  logic [ADDR_W-1:0]        addr_sel;
  logic                     hit_rb, hit_rc, is_mem, is_wr, is_alu, go_mem, retire;
  logic                     cin, c_msb, alu_c, alu_v;
  logic [DATA_W:0]          sum, shl;
  logic signed [DATA_W:0]   shr;
  logic signed [SH_W:0]     sh_s;
  logic [SH_W:0]            sh_mag;
  logic [PC_W-1:0]          pc_inc, pc_next;
  logic [3:0]               flags_new;

  always_comb begin
    imm_ext  = {{(DATA_W-IMM_W){ir_imm[IMM_W-1]}}, ir_imm};
    is_wr    = (ir_op == OP_WRW) || (ir_op == OP_WRWB);
    addr_sel = ((ir_op == OP_RDWB) || (ir_op == OP_WRWB)) ? reg_b[ADDR_W-1:0]
                                                          : imm_ext[ADDR_W-1:0];
    hit_rb   = (addr_sel == RB_A);
    hit_rc   = (addr_sel == RC_A);
    is_mem   = ir_op inside {OP_RDW, OP_WRW, OP_RDWB, OP_WRWB, OP_ADD, OP_SUB, OP_AND, OP_XOR};
    is_alu   = ir_op inside {OP_ADDI, OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_SHFT};
    go_mem   = (state == EXEC) && is_mem && !hit_rb && !hit_rc;
    retire   = ((state == EXEC) && !go_mem) || ((state == MEM) && bus.data_mem_ack);

    if (state == MEM)  opnd = bus.data_from_mem;
    else if (hit_rb)   opnd = reg_b;
    else if (hit_rc)   opnd = {{(DATA_W-4){1'b0}}, reg_c};
    else               opnd = '0;

    // Subtraction is addition of the one's complement plus a carry-in.
    cin   = (ir_op == OP_SUB);
    b_x   = (ir_op == OP_ADDI) ? imm_ext : (cin ? ~opnd : opnd);
    sum   = {1'b0, reg_a} + {1'b0, b_x} + {{DATA_W{1'b0}}, cin};
    c_msb = sum[DATA_W-1] ^ reg_a[DATA_W-1] ^ b_x[DATA_W-1];

    sh_s   = {ir_imm[SH_W-1], ir_imm[SH_W-1:0]};
    sh_mag = sh_s[SH_W] ? -sh_s : sh_s;
    shl    = {1'b0, reg_a} << sh_mag;
    // Extra LSB catches the last bit shifted out on the right.
    shr    = $signed({reg_a, 1'b0}) >>> sh_mag;

    alu_res = reg_a;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ir_op)
      OP_ADDI, OP_ADD, OP_SUB: begin
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_v   = c_msb ^ sum[DATA_W];
      end
      OP_AND: alu_res = reg_a & opnd;
      OP_XOR: alu_res = reg_a ^ opnd;
      OP_SHFT: begin
        if (sh_s[SH_W]) begin
          alu_res = shr[DATA_W:1];
          alu_c   = shr[0];
        end else if (sh_s != '0) begin
          alu_res = shl[DATA_W-1:0];
          alu_c   = shl[DATA_W];
          alu_v   = shl[DATA_W-1] ^ reg_a[DATA_W-1];
        end
      end
      default: ;
    endcase
    flags_new = {(alu_res == '0), alu_res[DATA_W-1], alu_v, alu_c};

    pc_inc = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
    case (ir_op)
      OP_BEQI:  pc_next = (reg_a == '0) ? imm_ext[PC_W-1:0] : pc_inc;
      OP_BNEQI: pc_next = (reg_a != '0) ? imm_ext[PC_W-1:0] : pc_inc;
      OP_BEQ:   pc_next = (reg_a == '0) ? reg_b[PC_W-1:0] : pc_inc;
      OP_BNEQ:  pc_next = (reg_a != '0) ? reg_b[PC_W-1:0] : pc_inc;
      default:  pc_next = pc_inc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      ir_op       <= OP_NOP;
      ir_imm      <= '0;
      reg_a       <= '0;
      reg_b       <= '0;
      reg_c       <= '0;
      pc_r        <= '0;
      instr_req_r <= 1'b0;
      sel_r       <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= '0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        FETCH: begin
          // An ack only counts once the request is actually on the bus.
          if (instr_req_r && bus.instr_ack) begin
            ir_op       <= bus.instruction[INSTR_W-1 -: OPCODESZ];
            ir_imm      <= bus.instruction[IMM_W-1:0];
            instr_req_r <= 1'b0;
            state       <= EXEC;
          end else begin
            instr_req_r <= 1'b1;
          end
        end
        EXEC: begin
          if (go_mem) begin
            sel_r  <= 1'b1;
            we_r   <= is_wr;
            addr_r <= addr_sel;
            state  <= MEM;
          end
        end
        MEM: begin
          if (bus.data_mem_ack) begin
            sel_r <= 1'b0;
            we_r  <= 1'b0;
          end
        end
        default: state <= FETCH;
      endcase

      if (retire) begin
        done_r      <= 1'b1;
        instr_req_r <= 1'b1;
        pc_r        <= pc_next;
        state       <= FETCH;
        if (is_alu) begin
          reg_a <= alu_res;
          reg_c <= flags_new;
        end
        case (ir_op)
          OP_LDI:          reg_a <= imm_ext;
          OP_LDIH:         reg_a <= {ir_imm[DATA_W/2-1:0], reg_a[DATA_W/2-1:0]};
          OP_RDW, OP_RDWB: reg_a <= opnd;
          OP_WRW, OP_WRWB: if (hit_rb) reg_b <= reg_a;
          default: ;
        endcase
      end
    end
  end

  assign bus.instr_req     = instr_req_r;
  assign bus.pc            = pc_r;
  assign bus.data_mem_sel  = sel_r;
  assign bus.data_mem_we   = we_r;
  assign bus.data_mem_addr = addr_r;
  assign bus.data_to_mem   = reg_a;
  assign bus.flags         = reg_c;
  assign bus.instr_done    = done_r;

endmodule

// File: tb/tb_xctrl_mc.sv
// Directed bench for xctrl_mc: zero-wait program memory, data memory with programmable wait states.
module tb_xctrl_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xctrl_mc_if #(.DATA_W(32), .ADDR_W(16), .PC_W(15), .INSTR_W(32)) bus ();

  xctrl_mc dut (.clk(clk), .rst(rst), .bus(bus.master));

  localparam logic [4:0] NOP = 5'd0, LDI = 5'd1, LDIH = 5'd2, ADDI = 5'd3, RDW = 5'd4,
                         WRW = 5'd5, ADD = 5'd8, SUB = 5'd9, AND = 5'd10, XOR = 5'd11,
                         SHFT = 5'd12, BEQI = 5'd13, BNEQI = 5'd14, BEQ = 5'd15, BNEQ = 5'd16,
                         UNDEF = 5'd31;

  logic [31:0] prog [0:255];
  int dmem_wait = 0;
  int dcnt = 0;
  int wr_cnt = 0;
  int sel_rises = 0;
  logic sel_q = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  assign bus.instruction   = prog[bus.pc[7:0]];
  assign bus.instr_ack     = bus.instr_req;
  assign bus.data_mem_ack  = bus.data_mem_sel && (dcnt >= dmem_wait);
  assign bus.data_from_mem = (bus.data_mem_addr == 16'h0020) ? 32'h1234_5678 : 32'h0;

  always @(posedge clk) begin
    if (!bus.data_mem_sel) dcnt <= 0;
    else if (!bus.data_mem_ack) dcnt <= dcnt + 1;
    sel_q <= bus.data_mem_sel;
    if (bus.data_mem_sel && !sel_q) sel_rises <= sel_rises + 1;
    if (bus.data_mem_sel && bus.data_mem_we && bus.data_mem_ack) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= bus.data_mem_addr;
      wr_data <= bus.data_to_mem;
    end
  end

  int compared = 0;
  int mismatched = 0;

  function automatic logic [31:0] ins(input logic [4:0] op, input logic [15:0] imm);
    return {op, 11'b0, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.instr_done !== 1'b1 && cyc < 40);
    if (bus.instr_done !== 1'b1) chk({tag, " timeout"}, {31'b0, bus.instr_done}, 32'd1);
  endtask

  task automatic step(input string tag, input logic [31:0] ea, input logic [3:0] ef,
                      input logic [14:0] epc, input int elat);
    int cyc;
    wait_done(tag, cyc);
    chk({tag, " regA"}, bus.data_to_mem, ea);
    chk({tag, " flags"}, {28'b0, bus.flags}, {28'b0, ef});
    chk({tag, " pc"}, {17'b0, bus.pc}, {17'b0, epc});
    if (elat > 0) chk({tag, " latency"}, cyc, elat);
  endtask

  task automatic reset_and_check(input string tag);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk({tag, " req"}, {31'b0, bus.instr_req}, 32'd0);
    chk({tag, " sel"}, {31'b0, bus.data_mem_sel}, 32'd0);
    chk({tag, " pc"}, {17'b0, bus.pc}, 32'd0);
    chk({tag, " flags"}, {28'b0, bus.flags}, 32'd0);
    chk({tag, " regA"}, bus.data_to_mem, 32'd0);
    chk({tag, " done"}, {31'b0, bus.instr_done}, 32'd0);
  endtask

  initial begin
    int n, sel_cyc, rises0, cyc;
    for (int i = 0; i < 256; i++) prog[i] = ins(NOP, 16'h0);

    // Arithmetic, flags, shifts and a wait-stated external write
    prog[0]  = ins(LDI, 16'd5);
    prog[1]  = ins(ADDI, 16'hFFFB);
    prog[2]  = ins(LDI, 16'hFFFF);
    prog[3]  = ins(LDIH, 16'h7FFF);
    prog[4]  = ins(ADDI, 16'd1);
    prog[5]  = ins(LDI, 16'h00F0);
    prog[6]  = ins(SHFT, 16'hFFFC);
    prog[7]  = ins(SHFT, 16'd4);
    prog[8]  = ins(SHFT, 16'hFFFB);
    prog[9]  = ins(SHFT, 16'd0);
    prog[10] = ins(SHFT, 16'd31);
    prog[11] = ins(WRW, 16'h0010);
    prog[12] = ins(UNDEF, 16'h1234);
    dmem_wait = 3;
    reset_and_check("reset0");
    rst = 1'b0;
    step("ldi5",    32'd5,          4'b0000, 15'd1, 0);
    step("addi-5",  32'd0,          4'b1001, 15'd2, 2);
    step("ldi-1",   32'hFFFF_FFFF,  4'b1001, 15'd3, 2);
    step("ldih",    32'h7FFF_FFFF,  4'b1001, 15'd4, 2);
    step("addi1",   32'h8000_0000,  4'b0110, 15'd5, 2);
    step("ldif0",   32'h0000_00F0,  4'b0110, 15'd6, 2);
    step("shft-4",  32'h0000_000F,  4'b0000, 15'd7, 2);
    step("shft4",   32'h0000_00F0,  4'b0000, 15'd8, 2);
    step("shft-5",  32'h0000_0007,  4'b0001, 15'd9, 2);
    step("shft0",   32'h0000_0007,  4'b0000, 15'd10, 2);
    step("shft31",  32'h8000_0000,  4'b0111, 15'd11, 2);

    sel_cyc = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.data_mem_sel) begin
        sel_cyc++;
        chk("wrw addr", {16'b0, bus.data_mem_addr}, 32'h10);
        chk("wrw we", {31'b0, bus.data_mem_we}, 32'd1);
        chk("wrw data", bus.data_to_mem, 32'h8000_0000);
        chk("wrw pc held", {17'b0, bus.pc}, 32'd11);
      end
    end while (bus.instr_done !== 1'b1 && n < 30);
    chk("wrw retire", {31'b0, bus.instr_done}, 32'd1);
    chk("wrw sel cycles", sel_cyc, 32'd4);
    chk("wrw sel dropped", {31'b0, bus.data_mem_sel}, 32'd0);
    chk("wrw pc", {17'b0, bus.pc}, 32'd12);
    chk("write count", wr_cnt, 32'd1);
    chk("write addr", {16'b0, wr_addr}, 32'h10);
    chk("write data", wr_data, 32'h8000_0000);
    step("undef", 32'h8000_0000, 4'b0111, 15'd13, 2);

    // Branches, internal regB/regC mapping, zero-wait external reads
    for (int i = 0; i < 256; i++) prog[i] = ins(NOP, 16'h0);
    prog[8'h00] = ins(BEQI, 16'h0020);
    prog[8'h20] = ins(LDI, 16'd1);
    prog[8'h21] = ins(BEQI, 16'h0040);
    prog[8'h22] = ins(LDI, 16'h0030);
    prog[8'h23] = ins(WRW, 16'hFFFE);
    prog[8'h24] = ins(LDI, 16'd0);
    prog[8'h25] = ins(BNEQ, 16'h0);
    prog[8'h26] = ins(BEQ, 16'h0);
    prog[8'h30] = ins(ADDI, 16'hFFFF);
    prog[8'h31] = ins(RDW, 16'hFFFF);
    prog[8'h32] = ins(BNEQI, 16'h0040);
    prog[8'h40] = ins(ADD, 16'hFFFE);
    prog[8'h41] = ins(RDW, 16'h0020);
    prog[8'h42] = ins(SUB, 16'h0020);
    prog[8'h43] = ins(XOR, 16'hFFFE);
    prog[8'h44] = ins(AND, 16'hFFFF);
    prog[8'h45] = ins(LDI, 16'd2);
    prog[8'h46] = ins(BNEQ, 16'h0);
    dmem_wait = 0;
    reset_and_check("reset1");
    rst = 1'b0;
    step("beqi taken",   32'd0,         4'b0000, 15'h20, 0);
    step("ldi1",         32'd1,         4'b0000, 15'h21, 2);
    step("beqi not",     32'd1,         4'b0000, 15'h22, 2);
    step("ldi30",        32'h30,        4'b0000, 15'h23, 2);
    rises0 = sel_rises;
    step("wrw regB",     32'h30,        4'b0000, 15'h24, 2);
    chk("wrw regB no bus", sel_rises, rises0);
    step("ldi0",         32'd0,         4'b0000, 15'h25, 2);
    step("bneq not",     32'd0,         4'b0000, 15'h26, 2);
    step("beq taken",    32'd0,         4'b0000, 15'h30, 2);
    step("addi-1",       32'hFFFF_FFFF, 4'b0100, 15'h31, 2);
    step("rdw regC",     32'h4,         4'b0100, 15'h32, 2);
    step("bneqi taken",  32'h4,         4'b0100, 15'h40, 2);
    step("add regB",     32'h34,        4'b0000, 15'h41, 2);
    step("rdw ext",      32'h1234_5678, 4'b0000, 15'h42, 3);
    step("sub ext",      32'd0,         4'b1001, 15'h43, 3);
    step("xor regB",     32'h30,        4'b0000, 15'h44, 2);
    step("and regC",     32'd0,         4'b1000, 15'h45, 2);
    chk("internal ops no bus", sel_rises, rises0 + 2);
    step("ldi2",         32'd2,         4'b1000, 15'h46, 2);
    step("bneq taken",   32'd2,         4'b1000, 15'h30, 2);

    // pc wrap, then reset while a write is stalled
    for (int i = 0; i < 256; i++) prog[i] = ins(NOP, 16'h0);
    prog[8'h00] = ins(BEQI, 16'h7FFF);
    prog[8'hFF] = ins(LDI, 16'd7);
    prog[8'h01] = ins(WRW, 16'h0010);
    dmem_wait = 1000;
    reset_and_check("reset2");
    rst = 1'b0;
    step("beqi top",   32'd0, 4'b0000, 15'h7FFF, 0);
    step("pc wrap",    32'd7, 4'b0000, 15'h0000, 2);
    step("beqi not",   32'd7, 4'b0000, 15'h0001, 2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.data_mem_sel !== 1'b1 && n < 20);
    chk("stall sel", {31'b0, bus.data_mem_sel}, 32'd1);
    repeat (2) @(negedge clk);
    chk("stall pc held", {17'b0, bus.pc}, 32'd1);
    chk("stall sel held", {31'b0, bus.data_mem_sel}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async rst sel", {31'b0, bus.data_mem_sel}, 32'd0);
    chk("async rst req", {31'b0, bus.instr_req}, 32'd0);
    chk("async rst pc", {17'b0, bus.pc}, 32'd0);
    repeat (2) @(negedge clk);
    chk("no stray write", wr_cnt, 32'd1);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.instr_req !== 1'b1 && n < 20);
    chk("refetch req", {31'b0, bus.instr_req}, 32'd1);
    chk("refetch pc", {17'b0, bus.pc}, 32'd0);
    step("after rst", 32'd0, 4'b0000, 15'h7FFF, 0);
    wait_done("idle", cyc);
    chk("final write count", wr_cnt, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
